// File: rtl/ret_stack_pkg.sv
// Shared definitions for the microc return-address stack: PC width,
// overflow policy selectors and the per-edge operation decode.
package ret_stack_pkg;

    // Program counter width shared by microc and the return stack.
    localparam int PC_WIDTH = 10;

    // Push-when-full policy selectors for OVF_MODE.
    localparam int RS_OVF_SATURATE = 0;
    localparam int RS_OVF_WRAP     = 1;

    // Operation requested on an edge, encoded directly as {push, pop}.
    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

endpackage : ret_stack_pkg

// File: rtl/ret_stack.sv
// Return-address stack for microc: a circular buffer of DEPTH entries with
// a next-free-slot pointer and an occupancy counter. The top entry is read
// combinationally so the PC can load it in the same cycle it is popped.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int WIDTH    = PC_WIDTH,
    parameter int DEPTH    = 4,
    parameter int OVF_MODE = RS_OVF_SATURATE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [PTR_W-1:0] w_sp_inc;
    logic [PTR_W-1:0] w_sp_dec;
    logic             w_full;
    logic             w_empty;
    op_e              w_op;

    logic             w_mem_we;
    logic [PTR_W-1:0] w_mem_addr;
    logic [PTR_W-1:0] w_sp_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_set_err;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign w_sp_inc = (r_sp == LAST_SLOT) ? '0 : r_sp + 1'b1;
    assign w_sp_dec = (r_sp == '0) ? LAST_SLOT : r_sp - 1'b1;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_op    = op_e'({push, pop});

    // Decode the requested operation against the current occupancy.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        w_mem_we   = 1'b0;
        w_mem_addr = r_sp;
        w_sp_next  = r_sp;
        w_cnt_next = r_count;
        w_set_err  = 1'b0;
        case (w_op)
            OP_HOLD: begin
            end
            OP_PUSH: begin
                if (!w_full) begin
                    w_mem_we   = 1'b1;
                    w_sp_next  = w_sp_inc;
                    w_cnt_next = r_count + 1'b1;
                end else if (OVF_MODE == RS_OVF_WRAP) begin
                    // Overwrite the oldest entry; occupancy stays at DEPTH.
                    w_mem_we  = 1'b1;
                    w_sp_next = w_sp_inc;
                    w_set_err = 1'b1;
                end else begin
                    w_set_err = 1'b1;
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_sp_next  = w_sp_dec;
                    w_cnt_next = r_count - 1'b1;
                end else begin
                    w_set_err = 1'b1;
                end
            end
            OP_REPLACE: begin
                if (!w_empty) begin
                    // Tail call: overwrite the current top in place.
                    w_mem_we   = 1'b1;
                    w_mem_addr = w_sp_dec;
                end else begin
                    // Nothing to pop, so only the push half takes effect.
                    w_mem_we   = 1'b1;
                    w_sp_next  = w_sp_inc;
                    w_cnt_next = r_count + 1'b1;
                    w_set_err  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Storage write port.
    // NOTE: the array has no reset; occupancy is tracked by r_count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= data_in;
        end
    end

    // Stack pointer and occupancy update.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp    <= '0;
            r_count <= '0;
        end else begin
            r_sp    <= w_sp_next;
            r_count <= w_cnt_next;
        end
    end

    // Sticky error flag; a new error on the same edge beats a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end else if (clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_sp_dec];
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;
    assign err   = r_err;

endmodule : ret_stack
